// File: rtl/xs3_pkg.sv
// Shared Excess-3 definitions: code range, bias and the converter FSM state encoding.
// Also imported by the Excess-3 adder benches.
package xs3_pkg;

  localparam int unsigned XS3_BIAS = 3;
  localparam logic [3:0]  XS3_MIN  = 4'd3;
  localparam logic [3:0]  XS3_MAX  = 4'd12;

  // Converter FSM encoding
  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StConv = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/xs3_to_bin_converter_if.sv
// Handshake bundle for the Excess-3 to binary converter.
//   in_valid/in_ready/in_xs3     : word input, valid/ready
//   out_valid/out_ready/out_bin/out_err : result output, valid/ready
// master = producer/consumer side (bench or upstream), slave = converter.
interface xs3_to_bin_converter_if #(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned BIN_W   = 14
);
  logic                   in_valid;
  logic                   in_ready;
  logic [4*NDIGITS-1:0]   in_xs3;
  logic                   out_valid;
  logic                   out_ready;
  logic [BIN_W-1:0]       out_bin;
  logic                   out_err;

  modport master (
    output in_valid, in_xs3, out_ready,
    input  in_ready, out_valid, out_bin, out_err
  );

  modport slave (
    input  in_valid, in_xs3, out_ready,
    output in_ready, out_valid, out_bin, out_err
  );
endinterface

// File: rtl/xs3_digit_decode.sv
// Combinational Excess-3 digit decoder.
//   code_i    : 4-bit Excess-3 code
//   digit_o   : decimal digit 0..9 (0 when the code is illegal)
//   illegal_o : code outside 3..12
module xs3_digit_decode
  import xs3_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [3:0] digit_o,
  output logic       illegal_o
);

  always_comb begin
    illegal_o = (code_i < XS3_MIN) || (code_i > XS3_MAX);
    digit_o   = illegal_o ? 4'd0 : (code_i - 4'(XS3_BIAS));
  end

endmodule

// File: rtl/xs3_to_bin_converter.sv
// Sequential Excess-3 to binary converter, one digit per clock, MSD first,
// accumulating acc = acc*10 + digit. Illegal codes count as 0 and set a sticky error.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of xs3_to_bin_converter_if (input word and result handshakes)
module xs3_to_bin_converter
  import xs3_pkg::*;
#(
  parameter int unsigned NDIGITS = 4,
  parameter int unsigned BIN_W   = 14
) (
  input logic                    clk,
  input logic                    rst_n,
  xs3_to_bin_converter_if.slave  bus
);

  localparam int unsigned CntW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int unsigned SrW  = 4 * NDIGITS;
  localparam logic [CntW-1:0] LastCnt = CntW'(NDIGITS - 1);

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [SrW-1:0]   sr_q, sr_d;
  logic [BIN_W-1:0] acc_q, acc_d;
  logic             err_q, err_d;

  logic [3:0] head_digit;
  logic       head_illegal;

  xs3_digit_decode u_decode (
    .code_i    (sr_q[SrW-1 -: 4]),
    .digit_o   (head_digit),
    .illegal_o (head_illegal)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    acc_d   = acc_q;
    err_d   = err_q;
    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          sr_d    = bus.in_xs3;
          acc_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = StConv;
        end
      end
      StConv: begin
        // acc*10 as (acc<<3)+(acc<<1), wrapping at BIN_W
        acc_d = (acc_q << 3) + (acc_q << 1) + BIN_W'(head_digit);
        err_d = err_q | head_illegal;
        sr_d  = sr_q << 4;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sr_q    <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  // Result is only exposed in DONE so partial sums never leak onto the bus
  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_bin   = (state_q == StDone) ? acc_q : '0;
  assign bus.out_err   = (state_q == StDone) & err_q;

endmodule
